// File: rtl/serial_transmitter_if.sv
// serial_transmitter_if
// Producer-side handshake bundle for the serial transmitter.
//   tx_data  : word to send, qualified by tx_valid
//   tx_valid : producer has a word
//   tx_ready : transmitter can accept a word this cycle
// Modports:
//   master : producer (FIFO / control logic) driving words in
//   slave  : the transmitter consuming words
interface serial_transmitter_if #(
  parameter int DATA_WIDTH = 8
) ();
  logic [DATA_WIDTH-1:0] tx_data;
  logic                  tx_valid;
  logic                  tx_ready;

  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready
  );
endinterface

// File: rtl/serial_transmitter.sv
// serial_transmitter
// Parallel-to-serial transmitter for the single-wire framed serial link.
// Each accepted word is sent as one frame on `out`:
//   start bit (1), DATA_WIDTH data bits LSB first, odd parity bit, stop bit (1).
// Each bit is held for CLKS_PER_BIT clocks; the idle line level is 0.
// A stop bit may be followed directly by the next start bit.
//
// Parameters:
//   DATA_WIDTH   : payload bits per frame
//   CLKS_PER_BIT : clocks per bit (>= 1; 1 when feeding the existing receiver)
//
// Ports:
//   clk   : system clock, rising edge
//   rst   : synchronous, active-high reset (aborts any frame in flight)
//   tx_if : slave side of the valid/ready word handshake
//   out   : serial line, registered, 0 when idle
//   busy  : registered, 1 while a frame (START..STOP) is on the line
//   done  : registered, one-cycle pulse on the final clock of the stop bit
//
// Build option:
//   TX_SKID_EN : when defined, adds a one-entry holding register (word +
//                parity) so the producer can hand over the next word at any
//                point during a frame. Line format and timing are unchanged.
module serial_transmitter #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  serial_transmitter_if.slave     tx_if,
  output logic                    out,
  output logic                    busy,
  output logic                    done
);

  // Counters need at least one bit even when the range collapses to a single value.
  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W  = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_e;

  // Odd parity: data plus parity bit always carries an odd number of ones.
  function automatic logic odd_parity(input logic [DATA_WIDTH-1:0] d);
    return ~(^d);
  endfunction

  state_e                  state_q, state_d;
  logic [BAUD_W-1:0]       baud_q, baud_d;
  logic [BIT_W-1:0]        bit_q, bit_d;
  logic [DATA_WIDTH-1:0]   shreg_q, shreg_d;
  logic                    par_q, par_d;
  logic                    out_q, out_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;

  logic                    baud_last_s;
  logic                    bit_last_s;
  logic                    stop_end_s;
  logic                    frame_slot_s;
  logic                    accept_s;
  logic                    ready_s;
  logic                    load_s;
  logic [DATA_WIDTH-1:0]   load_data_s;
  logic                    load_par_s;

`ifdef TX_SKID_EN
  logic [DATA_WIDTH-1:0]   skid_data_q, skid_data_d;
  logic                    skid_par_q, skid_par_d;
  logic                    skid_full_q, skid_full_d;
`endif

  assign baud_last_s  = (baud_q == BAUD_W'(CLKS_PER_BIT - 1));
  assign bit_last_s   = (bit_q == BIT_W'(DATA_WIDTH - 1));
  assign stop_end_s   = (state_q == S_STOP) && baud_last_s;
  // A new frame can begin from idle or straight after the last stop-bit clock.
  assign frame_slot_s = (state_q == S_IDLE) || stop_end_s;
  assign accept_s     = tx_if.tx_valid && tx_if.tx_ready;

`ifdef TX_SKID_EN
  assign ready_s = !skid_full_q;
`else
  assign ready_s = frame_slot_s;
`endif

  assign tx_if.tx_ready = ready_s;
  assign out            = out_q;
  assign busy           = busy_q;
  assign done           = done_q;

  // Choose whether a new frame starts next and where its word comes from.
  always_comb begin
    load_s      = 1'b0;
    load_data_s = tx_if.tx_data;
    load_par_s  = odd_parity(tx_if.tx_data);
`ifdef TX_SKID_EN
    skid_data_d = skid_data_q;
    skid_par_d  = skid_par_q;
    skid_full_d = skid_full_q;
    // A buffered word always goes before anything newly offered.
    if (frame_slot_s && skid_full_q) begin
      load_s      = 1'b1;
      load_data_s = skid_data_q;
      load_par_s  = skid_par_q;
      skid_full_d = 1'b0;
    end else if (frame_slot_s && accept_s) begin
      load_s = 1'b1;
    end else begin
      load_s = 1'b0;
    end
    // Words that cannot start a frame right now are parked in the buffer.
    if (accept_s && !(frame_slot_s && !skid_full_q)) begin
      skid_data_d = tx_if.tx_data;
      skid_par_d  = odd_parity(tx_if.tx_data);
      skid_full_d = 1'b1;
    end else begin
      skid_data_d = skid_data_d;
    end
`else
    if (frame_slot_s && accept_s) begin
      load_s = 1'b1;
    end else begin
      load_s = 1'b0;
    end
`endif
  end

  // Frame sequencer: next state, bit/baud counters and shift register.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    par_d   = par_q;
    case (state_q)
      S_IDLE: begin
        if (load_s) begin
          state_d = S_START;
          baud_d  = {BAUD_W{1'b0}};
          bit_d   = {BIT_W{1'b0}};
          shreg_d = load_data_s;
          par_d   = load_par_s;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_START: begin
        if (baud_last_s) begin
          state_d = S_DATA;
          baud_d  = {BAUD_W{1'b0}};
        end else begin
          baud_d = baud_q + BAUD_W'(1'b1);
        end
      end
      S_DATA: begin
        if (baud_last_s) begin
          baud_d  = {BAUD_W{1'b0}};
          shreg_d = {1'b0, shreg_q[DATA_WIDTH-1:1]};
          if (bit_last_s) begin
            state_d = S_PARITY;
            bit_d   = {BIT_W{1'b0}};
          end else begin
            bit_d = bit_q + BIT_W'(1'b1);
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1'b1);
        end
      end
      S_PARITY: begin
        if (baud_last_s) begin
          state_d = S_STOP;
          baud_d  = {BAUD_W{1'b0}};
        end else begin
          baud_d = baud_q + BAUD_W'(1'b1);
        end
      end
      S_STOP: begin
        if (baud_last_s) begin
          baud_d = {BAUD_W{1'b0}};
          bit_d  = {BIT_W{1'b0}};
          if (load_s) begin
            state_d = S_START;
            shreg_d = load_data_s;
            par_d   = load_par_s;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1'b1);
        end
      end
      default: begin
        state_d = S_IDLE;
        baud_d  = {BAUD_W{1'b0}};
        bit_d   = {BIT_W{1'b0}};
      end
    endcase
  end

  // Line outputs are decoded from the next state so they change on the same
  // edge as the state register (accept at edge k puts the start bit out at k).
  always_comb begin
    out_d  = 1'b0;
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_STOP) && (baud_d == BAUD_W'(CLKS_PER_BIT - 1));
    case (state_d)
      S_IDLE:   out_d = 1'b0;
      S_START:  out_d = 1'b1;
      S_DATA:   out_d = shreg_d[0];
      S_PARITY: out_d = par_d;
      S_STOP:   out_d = 1'b1;
      default:  out_d = 1'b0;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      baud_q  <= {BAUD_W{1'b0}};
      bit_q   <= {BIT_W{1'b0}};
      shreg_q <= {DATA_WIDTH{1'b0}};
      par_q   <= 1'b0;
      out_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      par_q   <= par_d;
      out_q   <= out_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

`ifdef TX_SKID_EN
  // Holding register for the next word while a frame is on the line.
  always_ff @(posedge clk) begin
    if (rst) begin
      skid_data_q <= {DATA_WIDTH{1'b0}};
      skid_par_q  <= 1'b0;
      skid_full_q <= 1'b0;
    end else begin
      skid_data_q <= skid_data_d;
      skid_par_q  <= skid_par_d;
      skid_full_q <= skid_full_d;
    end
  end
`endif

endmodule
